pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
- Multi-cycle fetch/PC controller for the LEGv8 core.
- Owns the program counter register and issues instruction-memory requests using a req/ack handshake.
- Waits for the execute stage to resolve branch controls, then computes and commits the next PC: CurrentPC+4, or CurrentPC+SignExtImm64 when the branch is taken.
- Sits between instruction memory and the decode/execute datapath, and replaces the free-running PC register.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
PC_INC, 4, sequential increment in bytes
MAX_WAIT, 15, max cycles imem_req may stay unacknowledged before a timeout fault (1..255)

Ports:
CLK  input  1  clock, rising edge
resetl  input  1  asynchronous active-low reset
run  input  1  level; 1 = keep fetching, 0 = stop at the next instruction boundary
imem_req  output  1  fetch request
imem_addr  output  64  fetch address, always equal to CurrentPC
imem_ack  input  1  instruction memory accepted/returned the word
instr_valid  output  1  one-cycle pulse: fetched word is valid for decode
res_valid  input  1  execute stage presents resolved branch controls this cycle
Branch  input  1  conditional branch (CBZ)
ALUZero  input  1  ALU zero flag
Uncondbranch  input  1  unconditional branch (B)
SignExtImm64  input  64  branch offset, already sign-extended and shifted
CurrentPC  output  64  architectural PC
busy  output  1  1 in FETCH or WAIT_RES
fault  output  1  sticky error flag
fault_cause  output  2  00 none, 01 fetch timeout, 10 misaligned target
retired  output  32  count of committed instructions

Behaviour:
- Reset (resetl=0, asynchronous, any state):
  - State=IDLE, CurrentPC=RESET_PC.
  - imem_req=0, instr_valid=0, busy=0, fault=0, fault_cause=00, retired=0, wait counter=0.
- State IDLE:
  - imem_req=0.
  - run=1 → FETCH on the next edge; otherwise stay.
- State FETCH:
  - imem_req=1, imem_addr=CurrentPC (combinational from the PC register).
  - imem_ack=1 → instr_valid=1 for exactly the following cycle (registered), wait counter cleared, go to WAIT_RES.
  - No ack → wait counter increments. If the counter reaches MAX_WAIT with no ack → FAULT, fault_cause=01.
  - res_valid is ignored in FETCH.
- State WAIT_RES:
  - imem_req=0; imem_ack is ignored.
  - Hold until res_valid=1.
  - taken = Uncondbranch | (Branch & ALUZero).
  - target = taken ? CurrentPC+SignExtImm64 : CurrentPC+PC_INC, computed modulo 2^64 (wrap silently, no carry out).
  - If target[1:0]!=00 → FAULT, fault_cause=10, CurrentPC unchanged, retired unchanged.
  - Otherwise CurrentPC<=target and retired<=retired+1 (wraps at 2^32).
  - Next state: FETCH if run=1, else IDLE.
- run=0 in FETCH does not abort an outstanding request; the instruction completes and the block stops in IDLE after commit.
- State FAULT:
  - imem_req=0, busy=0, fault=1; CurrentPC and retired frozen.
  - Exit only by reset; run has no effect.
- Latency, ack in the same cycle as req: FETCH→WAIT_RES takes 1 cycle. Minimum instruction period is 2 cycles (res_valid in the first WAIT_RES cycle).
- Simultaneous imem_ack and res_valid in FETCH: only the ack is acted on.
- Reset asserted mid-operation: any in-flight request is abandoned, no commit occurs, and the PC returns to RESET_PC.

Test Plan:
1. Hold resetl=0 for 3 cycles → CurrentPC=0, imem_req=0, fault=0, retired=0. Release, keep run=0 for 5 cycles → imem_req stays 0.
2. run=1, ack 2 cycles after req, res_valid with Branch/ALUZero/Uncondbranch=000 → imem_addr=0, instr_valid one pulse, CurrentPC=0x4, retired=1.
3. At PC=0x100:
   - Branch=1, ALUZero=1, imm=0x40 → PC=0x140.
   - Next instruction, Branch=1, ALUZero=0, imm=0x40 → PC=0x144.
   - Next, Branch=0, ALUZero=1 → PC=0x148.
4. From PC=0:
   - Uncondbranch=1, imm=64'hFFFFFFFFFFFFFFF0 → PC=64'hFFFFFFFFFFFFFFF0.
   - Then Uncondbranch=1, imm=0x20 → PC=0x10 (wrap).
   - Then Branch=1, ALUZero=1, Uncondbranch=1, imm=0x8 → PC=0x18.
5. Withhold imem_ack for 15 cycles → fault=1, fault_cause=01, imem_req=0. A late ack and toggling run have no effect; resetl pulse clears fault and sets PC=0.
6. At PC=0x10, Uncondbranch=1, imm=0x6 → fault_cause=10, PC stays 0x10, retired unchanged. Separately, assert resetl=0 during WAIT_RES → immediate return to IDLE, PC=0, no commit.

Source files
------------

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch bus between the PC/fetch sequencer and imem/decode.
interface pc_fetch_sequencer_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        output instr_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        input  instr_valid
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Multi-cycle fetch/PC controller for the LEGv8 core.
// Owns the architectural PC, fetches one word at a time over a req/ack bus,
// then waits for the execute stage to resolve the branch before committing
// the next PC.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | stopped at an instruction boundary, waiting for run
// S_FETCH    | imem_req high for CurrentPC, counting cycles without ack
// S_WAIT_RES | word delivered, waiting for resolved branch controls
// S_FAULT    | sticky error (timeout or misaligned target), reset only
module pc_fetch_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned PC_INC   = 4,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                        CLK,
    input  logic                        resetl,
    input  logic                        run,
    pc_fetch_sequencer_if.master        imem,
    input  logic                        res_valid,
    input  logic                        Branch,
    input  logic                        ALUZero,
    input  logic                        Uncondbranch,
    input  logic [63:0]                 SignExtImm64,
    output logic [63:0]                 CurrentPC,
    output logic                        busy,
    output logic                        fault,
    output logic [1:0]                  fault_cause,
    output logic [31:0]                 retired
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FETCH    = 2'd1,
        S_WAIT_RES = 2'd2,
        S_FAULT    = 2'd3
    } state_t;

    localparam logic [7:0]  WAIT_LAST   = 8'(MAX_WAIT - 1);
    localparam logic [63:0] INC         = 64'(PC_INC);
    localparam logic [1:0]  CAUSE_NONE  = 2'b00;
    localparam logic [1:0]  CAUSE_TMO   = 2'b01;
    localparam logic [1:0]  CAUSE_ALIGN = 2'b10;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] retired_q, retired_d;
    logic [1:0]  cause_q, cause_d;
    logic        ivalid_q, ivalid_d;
    logic        req;

    logic        taken;
    logic [63:0] target;

    // Branch resolution; additions wrap modulo 2^64 by construction.
    always_comb begin
        taken  = Uncondbranch | (Branch & ALUZero);
        target = taken ? (pc_q + SignExtImm64) : (pc_q + INC);
    end

    // State and datapath registers; reset abandons any in-flight fetch.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            wait_q    <= 8'd0;
            retired_q <= 32'd0;
            cause_q   <= CAUSE_NONE;
            ivalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            cause_q   <= cause_d;
            ivalid_q  <= ivalid_d;
        end
    end

    // Next-state, fetch request and commit decisions.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        wait_d    = wait_q;
        retired_d = retired_q;
        cause_d   = cause_q;
        ivalid_d  = 1'b0;
        req       = 1'b0;

        case (state_q)
            S_IDLE: begin
                wait_d = 8'd0;
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                req = 1'b1;
                // res_valid is deliberately not looked at here: an ack in
                // the same cycle always wins.
                if (imem.imem_ack) begin
                    ivalid_d = 1'b1;
                    wait_d   = 8'd0;
                    state_d  = S_WAIT_RES;
                end else if (wait_q == WAIT_LAST) begin
                    wait_d  = 8'd0;
                    cause_d = CAUSE_TMO;
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WAIT_RES: begin
                if (res_valid) begin
                    if (target[1:0] != 2'b00) begin
                        cause_d = CAUSE_ALIGN;
                        state_d = S_FAULT;
                    end else begin
                        pc_d      = target;
                        retired_d = retired_q + 32'd1;
                        state_d   = run ? S_FETCH : S_IDLE;
                    end
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output mapping.
    always_comb begin
        imem.imem_req    = req;
        imem.imem_addr   = pc_q;
        imem.instr_valid = ivalid_q;
        CurrentPC        = pc_q;
        busy             = (state_q == S_FETCH) || (state_q == S_WAIT_RES);
        fault            = (state_q == S_FAULT);
        fault_cause      = cause_q;
        retired          = retired_q;
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: a table of per-instruction vectors
// plus hand-written sequences for timeout, fault freeze and mid-op reset.
module tb_pc_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        resetl;
    logic        run;
    logic        res_valid;
    logic        Branch;
    logic        ALUZero;
    logic        Uncondbranch;
    logic [63:0] SignExtImm64;
    logic [63:0] CurrentPC;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] retired;

    pc_fetch_sequencer_if bus ();

    pc_fetch_sequencer dut (
        .CLK          (CLK),
        .resetl       (resetl),
        .run          (run),
        .imem         (bus.master),
        .res_valid    (res_valid),
        .Branch       (Branch),
        .ALUZero      (ALUZero),
        .Uncondbranch (Uncondbranch),
        .SignExtImm64 (SignExtImm64),
        .CurrentPC    (CurrentPC),
        .busy         (busy),
        .fault        (fault),
        .fault_cause  (fault_cause),
        .retired      (retired)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        do_rst;
        int          ack_dly;
        int          res_dly;
        logic        br;
        logic        zr;
        logic        ub;
        logic [63:0] imm;
        logic        stop;
        logic        junk;
        logic [63:0] exp_pc;
        logic [31:0] exp_ret;
        logic [1:0]  exp_cause;
    } vec_t;

    vec_t        tbl [11];
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] cur_pc;
    logic [31:0] cur_ret;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        run          = 1'b0;
        bus.imem_ack = 1'b0;
        res_valid    = 1'b0;
        Branch       = 1'b0;
        ALUZero      = 1'b0;
        Uncondbranch = 1'b0;
        SignExtImm64 = 64'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetl = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_pc", CurrentPC, 64'h0);
        chk("rst_req", {63'h0, bus.imem_req}, 64'h0);
        chk("rst_fault", {63'h0, fault}, 64'h0);
        chk("rst_cause", {62'h0, fault_cause}, 64'h0);
        chk("rst_retired", {32'h0, retired}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_ivalid", {63'h0, bus.instr_valid}, 64'h0);
        resetl  = 1'b1;
        cur_pc  = 64'h0;
        cur_ret = 32'h0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            if (bus.imem_req) break;
            @(negedge CLK);
        end
        chk("req_seen", {63'h0, bus.imem_req}, 64'h1);
    endtask

    task automatic run_vec(input vec_t v);
        if (v.do_rst) do_reset();
        run = 1'b1;
        wait_req();
        chk("fetch_addr", bus.imem_addr, cur_pc);
        if (v.stop) run = 1'b0;
        repeat (v.ack_dly) @(negedge CLK);
        chk("req_held", {63'h0, bus.imem_req}, 64'h1);
        bus.imem_ack = 1'b1;
        if (v.junk) begin
            res_valid    = 1'b1;
            Uncondbranch = 1'b1;
            SignExtImm64 = 64'h1000;
        end
        @(negedge CLK);
        bus.imem_ack = 1'b0;
        res_valid    = 1'b0;
        Uncondbranch = 1'b0;
        SignExtImm64 = 64'h0;
        chk("ivalid_pulse", {63'h0, bus.instr_valid}, 64'h1);
        chk("wait_req_low", {63'h0, bus.imem_req}, 64'h0);
        chk("wait_busy", {63'h0, busy}, 64'h1);
        chk("wait_pc_hold", CurrentPC, cur_pc);
        if (v.res_dly > 0) begin
            repeat (v.res_dly) @(negedge CLK);
            chk("ivalid_single", {63'h0, bus.instr_valid}, 64'h0);
            chk("wait_pc_hold2", CurrentPC, cur_pc);
        end
        Branch       = v.br;
        ALUZero      = v.zr;
        Uncondbranch = v.ub;
        SignExtImm64 = v.imm;
        res_valid    = 1'b1;
        @(negedge CLK);
        res_valid    = 1'b0;
        Branch       = 1'b0;
        ALUZero      = 1'b0;
        Uncondbranch = 1'b0;
        SignExtImm64 = 64'h0;
        chk("commit_pc", CurrentPC, v.exp_pc);
        chk("commit_retired", {32'h0, retired}, {32'h0, v.exp_ret});
        chk("commit_cause", {62'h0, fault_cause}, {62'h0, v.exp_cause});
        chk("commit_fault", {63'h0, fault}, {63'h0, (v.exp_cause != 2'b00)});
        if (v.exp_cause != 2'b00 || v.stop) begin
            chk("stop_req", {63'h0, bus.imem_req}, 64'h0);
            chk("stop_busy", {63'h0, busy}, 64'h0);
            repeat (3) @(negedge CLK);
            chk("stop_req_hold", {63'h0, bus.imem_req}, 64'h0);
            chk("stop_pc_hold", CurrentPC, v.exp_pc);
            run = 1'b1;
        end else begin
            chk("next_fetch", {63'h0, bus.imem_req}, {63'h0, run});
        end
        cur_pc  = v.exp_pc;
        cur_ret = v.exp_ret;
    endtask

    initial begin
        //        rst   ack res br    zr    ub    imm                     stop  junk  exp_pc                  ret    cause
        tbl[0]  = '{1'b0, 2, 1, 1'b0, 1'b0, 1'b0, 64'h0,                  1'b0, 1'b0, 64'h4,                  32'd1, 2'b00};
        tbl[1]  = '{1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 64'hFC,                 1'b0, 1'b1, 64'h100,                32'd2, 2'b00};
        tbl[2]  = '{1'b0, 1, 2, 1'b1, 1'b1, 1'b0, 64'h40,                 1'b0, 1'b0, 64'h140,                32'd3, 2'b00};
        tbl[3]  = '{1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 64'h40,                 1'b0, 1'b0, 64'h144,                32'd4, 2'b00};
        tbl[4]  = '{1'b0, 3, 1, 1'b0, 1'b1, 1'b0, 64'h40,                 1'b1, 1'b0, 64'h148,                32'd5, 2'b00};
        tbl[5]  = '{1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 32'd1, 2'b00};
        tbl[6]  = '{1'b0, 1, 0, 1'b0, 1'b0, 1'b1, 64'h20,                 1'b0, 1'b0, 64'h10,                 32'd2, 2'b00};
        tbl[7]  = '{1'b0, 0, 1, 1'b1, 1'b1, 1'b1, 64'h8,                  1'b0, 1'b0, 64'h18,                 32'd3, 2'b00};
        tbl[8]  = '{1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 64'h0,                  1'b0, 1'b0, 64'h1C,                 32'd4, 2'b00};
        tbl[9]  = '{1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 64'h10,                 1'b0, 1'b0, 64'h10,                 32'd1, 2'b00};
        tbl[10] = '{1'b0, 1, 1, 1'b0, 1'b0, 1'b1, 64'h6,                  1'b0, 1'b0, 64'h10,                 32'd1, 2'b10};

        resetl = 1'b0;
        clear_inputs();

        // Reset, then idle with run low.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("idle_req", {63'h0, bus.imem_req}, 64'h0);
        end

        for (int i = 0; i < 11; i++) run_vec(tbl[i]);

        // Misaligned fault stays frozen; run has no effect.
        run = 1'b0;
        repeat (2) @(negedge CLK);
        run = 1'b1;
        repeat (2) @(negedge CLK);
        chk("align_frozen_fault", {63'h0, fault}, 64'h1);
        chk("align_frozen_pc", CurrentPC, 64'h10);
        chk("align_frozen_req", {63'h0, bus.imem_req}, 64'h0);

        // Fetch timeout: 15 FETCH cycles without ack.
        do_reset();
        run = 1'b1;
        @(negedge CLK);
        chk("tmo_req_start", {63'h0, bus.imem_req}, 64'h1);
        repeat (14) @(negedge CLK);
        chk("tmo_req_14", {63'h0, bus.imem_req}, 64'h1);
        chk("tmo_fault_14", {63'h0, fault}, 64'h0);
        @(negedge CLK);
        chk("tmo_fault", {63'h0, fault}, 64'h1);
        chk("tmo_cause", {62'h0, fault_cause}, 64'h1);
        chk("tmo_req", {63'h0, bus.imem_req}, 64'h0);
        chk("tmo_busy", {63'h0, busy}, 64'h0);
        bus.imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run = ~run;
            @(negedge CLK);
        end
        bus.imem_ack = 1'b0;
        chk("tmo_late_fault", {63'h0, fault}, 64'h1);
        chk("tmo_late_cause", {62'h0, fault_cause}, 64'h1);
        chk("tmo_late_req", {63'h0, bus.imem_req}, 64'h0);
        chk("tmo_late_ivalid", {63'h0, bus.instr_valid}, 64'h0);
        chk("tmo_late_pc", CurrentPC, 64'h0);
        do_reset();

        // Reset asserted during WAIT_RES together with a resolving branch.
        run_vec('{1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 64'h10, 1'b0, 1'b0, 64'h10, 32'd1, 2'b00});
        wait_req();
        bus.imem_ack = 1'b1;
        @(negedge CLK);
        bus.imem_ack = 1'b0;
        chk("mid_wait_busy", {63'h0, busy}, 64'h1);
        res_valid    = 1'b1;
        Uncondbranch = 1'b1;
        SignExtImm64 = 64'h20;
        resetl       = 1'b0;
        #1;
        chk("mid_rst_pc", CurrentPC, 64'h0);
        chk("mid_rst_busy", {63'h0, busy}, 64'h0);
        chk("mid_rst_retired", {32'h0, retired}, 64'h0);
        @(posedge CLK);
        #1;
        chk("mid_rst_pc_edge", CurrentPC, 64'h0);
        chk("mid_rst_req_edge", {63'h0, bus.imem_req}, 64'h0);
        @(negedge CLK);
        clear_inputs();
        resetl = 1'b1;
        @(negedge CLK);
        chk("mid_rst_idle", {63'h0, busy}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
